ps2_cmd_sequencer: RTL and testbench
====================================

PS2_CMD_SEQUENCER -- requirements
Module: ps2_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000: maximum wait for a device response byte.
REQ-002 SHALL have parameter BAT_CYCLES, default 50000000: maximum wait for the self-test result after reset command 0xFF.
REQ-003 SHALL have parameter MAX_RETRY, default 3: number of resends allowed per byte.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its posedge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port cmd_valid, input, 1: command request.
REQ-007 SHALL have port cmd_ready, output, 1: sequencer idle and able to accept a command.
REQ-008 SHALL have port cmd_byte, input, 8: command opcode.
REQ-009 SHALL have port cmd_has_arg, input, 1: the command carries one argument byte.
REQ-010 SHALL have port cmd_arg, input, 8: argument byte.
REQ-011 SHALL have port tx_data, output, 8: byte to the PS/2 driver.
REQ-012 SHALL have port tx_valid, output, 1: valid for tx_data.
REQ-013 SHALL have port tx_ready, input, 1: driver accepts the byte.
REQ-014 SHALL have port rx_data, input, 8: byte from the driver.
REQ-015 SHALL have port rx_valid, input, 1: one-cycle strobe for rx_data.
REQ-016 SHALL have port scan_data, output, 8: forwarded non-response byte.
REQ-017 SHALL have port scan_valid, output, 1: one-cycle strobe for scan_data.
REQ-018 SHALL have port done, output, 1: one-cycle pulse when a command completes.
REQ-019 SHALL have port status, output, 2: result code; 0 OK, 1 TIMEOUT, 2 NAK/FAIL, 3 RETRY_EXHAUSTED.

Function
REQ-020 SHALL implement states IDLE, SEND_CMD, WAIT_CMD, SEND_ARG, WAIT_ARG, WAIT_BAT, DONE.
REQ-021 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready SHALL latch cmd_byte, cmd_has_arg and cmd_arg, clear the retry count, and enter SEND_CMD the next cycle.
REQ-022 SHALL drive tx_valid=1 in SEND_CMD and SEND_ARG only, with tx_data equal to the latched byte and held stable until tx_ready; on tx_valid&tx_ready SHALL enter WAIT_CMD or WAIT_ARG respectively and clear the timer.
REQ-023 SHALL, in WAIT_CMD or WAIT_ARG, handle rx byte 0xFA (ACK) as follows: WAIT_CMD goes to SEND_ARG if has_arg, else to WAIT_BAT if the command is 0xFF, else to DONE with status OK; WAIT_ARG goes to DONE with status OK.
REQ-024 SHALL, on rx byte 0xFE (RESEND) in a WAIT state, return to the matching SEND state and increment the retry count if retry count < MAX_RETRY, else go to DONE with status 3.
REQ-025 SHALL, on rx byte 0xFC in any WAIT state, go to DONE with status 2.
REQ-026 SHALL, in WAIT_BAT, go to DONE with status OK on 0xAA and with status 2 on 0xFC.
REQ-027 SHALL forward any other rx byte, including every byte received in IDLE/SEND/DONE, to scan_data/scan_valid one cycle after rx_valid, without a state change.
REQ-028 SHALL increment the timer every cycle in a WAIT state; at count TIMEOUT_CYCLES-1 (BAT_CYCLES-1 in WAIT_BAT) SHALL go to DONE with status 1.
REQ-029 SHALL give rx_valid priority over timer expiry in the same cycle.
REQ-030 SHALL clear the timer on every resend.
REQ-031 SHALL pulse done=1 for exactly the single DONE cycle and then return to IDLE; status SHALL hold until the next command is accepted.
REQ-032 SHALL size the timer as clog2(max(TIMEOUT_CYCLES, BAT_CYCLES)) bits, saturating with no wrap.

Reset
REQ-033 SHALL, on rst, set state to IDLE, tx_valid=0, scan_valid=0, done=0, status=0, and clear timer and retry count; scan_data and tx_data SHALL be 0.
REQ-034 SHALL abort an in-flight command on rst mid-operation without asserting done.

Structure
REQ-035 SHALL place the state encoding, the constants 0xFA, 0xFE, 0xFC, 0xAA and 0xFF, and the status codes in shared package ps2_pkg.
REQ-036 SHALL implement the timer as sub-module ps2_timeout_counter (clear, enable, limit, expired); all other logic is inline.

Verification
REQ-037 SHALL cover: cmd 0xED with arg 0x07, device replies FA, FA -> bytes ED then 07 sent, done with status 0.
REQ-038 SHALL cover: cmd 0xF4, replies FE, FE, FA -> 0xF4 sent 3 times, done with status 0.
REQ-039 SHALL cover: cmd 0xF4, replies FE four times (MAX_RETRY=3) -> 4 transmissions, done with status 3.
REQ-040 SHALL cover: cmd 0xFF, reply FA, then no BAT byte (BAT_CYCLES=200) -> done with status 1 exactly 200 cycles after the ACK.
REQ-041 SHALL cover: scan byte 0x1C arriving in WAIT_CMD, then FA -> scan_valid with 0x1C, then done with status 0.
REQ-042 SHALL cover: rst asserted in WAIT_ARG -> next cycle cmd_ready=1, no done pulse, tx_valid=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 command sequencer: FSM encoding,
// device protocol bytes and result codes.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_CMD,
        S_WAIT_CMD,
        S_SEND_ARG,
        S_WAIT_ARG,
        S_WAIT_BAT,
        S_DONE
    } ps2_state_e;

    typedef enum logic [1:0] {
        STS_OK      = 2'd0,
        STS_TIMEOUT = 2'd1,
        STS_FAIL    = 2'd2,
        STS_RETRY   = 2'd3
    } ps2_status_e;

    localparam logic [7:0] PS2_ACK       = 8'hFA;
    localparam logic [7:0] PS2_RESEND    = 8'hFE;
    localparam logic [7:0] PS2_FAIL      = 8'hFC;
    localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
    localparam logic [7:0] PS2_CMD_RESET = 8'hFF;

endpackage

// File: rtl/ps2_timeout_counter.sv
// Saturating response timer. 'limit' is the terminal count; expired is
// asserted while enabled and the count sits at that terminal value.
module ps2_timeout_counter #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == limit);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Sends a PS/2 host command (plus optional argument), tracks ACK/RESEND/FAIL
// replies, waits for the self-test result after reset, and forwards scan bytes.
module ps2_cmd_sequencer
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int BAT_CYCLES     = 50000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] scan_data,
    output logic       scan_valid,
    output logic       done,
    output logic [1:0] status
);

    localparam int TMR_MAX = (TIMEOUT_CYCLES > BAT_CYCLES) ? TIMEOUT_CYCLES : BAT_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] BAT_LAST  = TMR_W'(BAT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRY);

    ps2_state_e       state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       arg_q, arg_d;
    logic             has_arg_q, has_arg_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    ps2_status_e      status_q, status_d;
    logic [7:0]       scan_data_q, scan_data_d;
    logic             scan_valid_q, scan_valid_d;

    logic             in_wait;
    logic             forward;
    logic             timer_clear;
    logic             timer_expired;
    logic [TMR_W-1:0] timer_limit;

    assign in_wait     = (state_q == S_WAIT_CMD) || (state_q == S_WAIT_ARG) ||
                         (state_q == S_WAIT_BAT);
    assign timer_limit = (state_q == S_WAIT_BAT) ? BAT_LAST : TO_LAST;
    // Restart the count on entry to every wait, including the CMD->BAT hop.
    assign timer_clear = !in_wait || (state_d != state_q);

    ps2_timeout_counter #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (in_wait),
        .limit  (timer_limit),
        .expired(timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        arg_d        = arg_q;
        has_arg_d    = has_arg_q;
        retry_d      = retry_q;
        status_d     = status_q;
        forward      = rx_valid && !in_wait;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_d     = cmd_byte;
                    arg_d     = cmd_arg;
                    has_arg_d = cmd_has_arg;
                    retry_d   = '0;
                    status_d  = STS_OK;
                    state_d   = S_SEND_CMD;
                end
            end
            S_SEND_CMD: if (tx_ready) state_d = S_WAIT_CMD;
            S_SEND_ARG: if (tx_ready) state_d = S_WAIT_ARG;
            S_WAIT_CMD, S_WAIT_ARG: begin
                // A received byte always wins over a same-cycle timeout.
                if (rx_valid) begin
                    case (rx_data)
                        PS2_ACK: begin
                            if (state_q == S_WAIT_ARG) begin
                                status_d = STS_OK;
                                state_d  = S_DONE;
                            end else if (has_arg_q) begin
                                retry_d = '0;
                                state_d = S_SEND_ARG;
                            end else if (cmd_q == PS2_CMD_RESET) begin
                                state_d = S_WAIT_BAT;
                            end else begin
                                status_d = STS_OK;
                                state_d  = S_DONE;
                            end
                        end
                        PS2_RESEND: begin
                            if (retry_q < RETRY_MAX) begin
                                retry_d = retry_q + 1'b1;
                                state_d = (state_q == S_WAIT_CMD) ? S_SEND_CMD : S_SEND_ARG;
                            end else begin
                                status_d = STS_RETRY;
                                state_d  = S_DONE;
                            end
                        end
                        PS2_FAIL: begin
                            status_d = STS_FAIL;
                            state_d  = S_DONE;
                        end
                        default: forward = 1'b1;
                    endcase
                end else if (timer_expired) begin
                    status_d = STS_TIMEOUT;
                    state_d  = S_DONE;
                end
            end
            S_WAIT_BAT: begin
                if (rx_valid) begin
                    case (rx_data)
                        PS2_BAT_OK: begin
                            status_d = STS_OK;
                            state_d  = S_DONE;
                        end
                        PS2_FAIL: begin
                            status_d = STS_FAIL;
                            state_d  = S_DONE;
                        end
                        default: forward = 1'b1;
                    endcase
                end else if (timer_expired) begin
                    status_d = STS_TIMEOUT;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        scan_valid_d = forward;
        scan_data_d  = forward ? rx_data : scan_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            arg_q        <= '0;
            has_arg_q    <= 1'b0;
            retry_q      <= '0;
            status_q     <= STS_OK;
            scan_data_q  <= '0;
            scan_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            arg_q        <= arg_d;
            has_arg_q    <= has_arg_d;
            retry_q      <= retry_d;
            status_q     <= status_d;
            scan_data_q  <= scan_data_d;
            scan_valid_q <= scan_valid_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign tx_valid   = (state_q == S_SEND_CMD) || (state_q == S_SEND_ARG);
    assign tx_data    = (state_q == S_SEND_ARG) ? arg_q :
                        (state_q == S_SEND_CMD) ? cmd_q : 8'h00;
    assign done       = (state_q == S_DONE);
    assign status     = status_q;
    assign scan_data  = scan_data_q;
    assign scan_valid = scan_valid_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed scenarios for the PS/2 command sequencer with hand-derived
// expectations (TIMEOUT_CYCLES=50, BAT_CYCLES=200, MAX_RETRY=3).
module tb_ps2_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_byte;
    logic       cmd_has_arg;
    logic [7:0] cmd_arg;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] scan_data;
    logic       scan_valid;
    logic       done;
    logic [1:0] status;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ps2_cmd_sequencer #(
        .TIMEOUT_CYCLES(50),
        .BAT_CYCLES    (200),
        .MAX_RETRY     (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_byte   (cmd_byte),
        .cmd_has_arg(cmd_has_arg),
        .cmd_arg    (cmd_arg),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .scan_data  (scan_data),
        .scan_valid (scan_valid),
        .done       (done),
        .status     (status)
    );

    // Stimulus helpers: each starts and ends just after a falling edge.
    task automatic issue_cmd(input logic [7:0] b, input logic has_arg, input logic [7:0] a);
        cmd_valid = 1'b1; cmd_byte = b; cmd_has_arg = has_arg; cmd_arg = a;
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("cmd %02h has_arg=%0d arg=%02h", b, has_arg, a);
    endtask

    task automatic take_tx(output logic [7:0] d, output bit ok);
        int i = 0;
        while (!tx_valid && i < 100) begin
            @(negedge clk);
            i++;
        end
        ok = tx_valid;
        d  = tx_data;
        if (ok) begin
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
            $display("tx byte %02h", d);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0;
        $display("rx byte %02h", b);
    endtask

    task automatic wait_done(output int n, output bit ok);
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = done;
        $display("done after %0d cycles status=%0d", n, status);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%02h want=00", tx_data); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (status !== 2'd0) begin bad++; $display("FAIL reset_status got=%0d want=0", status); end
        total++; if (scan_valid !== 1'b0 || scan_data !== 8'h00) begin bad++; $display("FAIL reset_scan got=%b/%02h want=0/00", scan_valid, scan_data); end
    endtask

    task automatic test_cmd_with_arg();
        logic [7:0] d; bit ok; int n;
        issue_cmd(8'hED, 1'b1, 8'h07);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL arg_busy got=%b want=0", cmd_ready); end
        take_tx(d, ok);
        total++; if (!ok || d !== 8'hED) begin bad++; $display("FAIL arg_tx_cmd got=%02h ok=%0d want=ED", d, ok); end
        send_rx(8'hFA);
        take_tx(d, ok);
        total++; if (!ok || d !== 8'h07) begin bad++; $display("FAIL arg_tx_arg got=%02h ok=%0d want=07", d, ok); end
        send_rx(8'hFA);
        wait_done(n, ok);
        total++; if (!ok || status !== 2'd0) begin bad++; $display("FAIL arg_done got=%0d/%0d want=1/0", ok, status); end
        @(negedge clk);
        total++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL arg_pulse got done=%b ready=%b want 0/1", done, cmd_ready); end
    endtask

    task automatic test_resend_ok();
        logic [7:0] d; bit ok; int n; int sent = 0;
        issue_cmd(8'hF4, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            take_tx(d, ok);
            if (ok && d == 8'hF4) sent++;
            send_rx((k < 2) ? 8'hFE : 8'hFA);
        end
        total++; if (sent !== 3) begin bad++; $display("FAIL resend_count got=%0d want=3", sent); end
        wait_done(n, ok);
        total++; if (!ok || status !== 2'd0) begin bad++; $display("FAIL resend_status got=%0d/%0d want=1/0", ok, status); end
        @(negedge clk);
    endtask

    task automatic test_retry_exhausted();
        logic [7:0] d; bit ok; int n; int sent = 0;
        issue_cmd(8'hF4, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            take_tx(d, ok);
            if (ok && d == 8'hF4) sent++;
            send_rx(8'hFE);
        end
        total++; if (sent !== 4) begin bad++; $display("FAIL exhaust_count got=%0d want=4", sent); end
        wait_done(n, ok);
        total++; if (!ok || n !== 0 || status !== 2'd3) begin bad++; $display("FAIL exhaust_status got=%0d/%0d/%0d want=1/0/3", ok, n, status); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL exhaust_tx got=%b want=0", tx_valid); end
        repeat (3) @(negedge clk);
        total++; if (status !== 2'd3) begin bad++; $display("FAIL exhaust_hold got=%0d want=3", status); end
    endtask

    task automatic test_bat_timeout();
        logic [7:0] d; bit ok; int n;
        issue_cmd(8'hFF, 1'b0, 8'h00);
        take_tx(d, ok);
        total++; if (!ok || d !== 8'hFF) begin bad++; $display("FAIL bat_tx got=%02h want=FF", d); end
        send_rx(8'hFA);
        wait_done(n, ok);
        total++; if (!ok || n !== 200) begin bad++; $display("FAIL bat_latency got=%0d want=200", n); end
        total++; if (status !== 2'd1) begin bad++; $display("FAIL bat_status got=%0d want=1", status); end
        @(negedge clk);
    endtask

    task automatic test_bat_results();
        logic [7:0] d; bit ok; int n;
        issue_cmd(8'hFF, 1'b0, 8'h00);
        take_tx(d, ok);
        send_rx(8'hFA);
        repeat (5) @(negedge clk);
        send_rx(8'hAA);
        wait_done(n, ok);
        total++; if (!ok || n !== 0 || status !== 2'd0) begin bad++; $display("FAIL bat_ok got=%0d/%0d/%0d want=1/0/0", ok, n, status); end
        @(negedge clk);
        issue_cmd(8'hFF, 1'b0, 8'h00);
        take_tx(d, ok);
        send_rx(8'hFA);
        send_rx(8'hFC);
        wait_done(n, ok);
        total++; if (!ok || n !== 0 || status !== 2'd2) begin bad++; $display("FAIL bat_fail got=%0d/%0d/%0d want=1/0/2", ok, n, status); end
        @(negedge clk);
    endtask

    task automatic test_cmd_timeout();
        logic [7:0] d; bit ok; int n;
        issue_cmd(8'hF5, 1'b0, 8'h00);
        take_tx(d, ok);
        wait_done(n, ok);
        total++; if (!ok || n !== 50 || status !== 2'd1) begin bad++; $display("FAIL cmd_timeout got=%0d/%0d/%0d want=1/50/1", ok, n, status); end
        @(negedge clk);
    endtask

    task automatic test_ack_beats_timeout();
        logic [7:0] d; bit ok; int n;
        issue_cmd(8'hF5, 1'b0, 8'h00);
        take_tx(d, ok);
        repeat (49) @(negedge clk);
        send_rx(8'hFA);
        wait_done(n, ok);
        total++; if (!ok || n !== 0 || status !== 2'd0) begin bad++; $display("FAIL ack_priority got=%0d/%0d/%0d want=1/0/0", ok, n, status); end
        @(negedge clk);
    endtask

    task automatic test_nak();
        logic [7:0] d; bit ok; int n;
        issue_cmd(8'hF3, 1'b1, 8'h20);
        take_tx(d, ok);
        send_rx(8'hFA);
        take_tx(d, ok);
        send_rx(8'hFC);
        wait_done(n, ok);
        total++; if (!ok || n !== 0 || status !== 2'd2) begin bad++; $display("FAIL nak_arg got=%0d/%0d/%0d want=1/0/2", ok, n, status); end
        @(negedge clk);
    endtask

    task automatic test_scan_forward();
        logic [7:0] d; bit ok; int n;
        send_rx(8'h55);
        total++; if (scan_valid !== 1'b1 || scan_data !== 8'h55) begin bad++; $display("FAIL scan_idle got=%b/%02h want=1/55", scan_valid, scan_data); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL scan_idle_state got=%b want=1", cmd_ready); end
        issue_cmd(8'hF4, 1'b0, 8'h00);
        take_tx(d, ok);
        send_rx(8'h1C);
        total++; if (scan_valid !== 1'b1 || scan_data !== 8'h1C || done !== 1'b0) begin bad++; $display("FAIL scan_wait got=%b/%02h done=%b want=1/1C/0", scan_valid, scan_data, done); end
        @(negedge clk);
        total++; if (scan_valid !== 1'b0) begin bad++; $display("FAIL scan_strobe got=%b want=0", scan_valid); end
        send_rx(8'hFA);
        wait_done(n, ok);
        total++; if (!ok || n !== 0 || status !== 2'd0) begin bad++; $display("FAIL scan_done got=%0d/%0d/%0d want=1/0/0", ok, n, status); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; bit ok; int seen = 0;
        issue_cmd(8'hED, 1'b1, 8'h02);
        take_tx(d, ok);
        send_rx(8'hFA);
        take_tx(d, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (cmd_ready !== 1'b1 || tx_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_reset got ready=%b tx=%b done=%b want 1/0/0", cmd_ready, tx_valid, done); end
        send_rx(8'hFA);
        for (int k = 0; k < 10; k++) begin
            if (done) seen++;
            @(negedge clk);
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_reset_done got=%0d pulses want=0", seen); end
        total++; if (scan_valid !== 1'b0 || scan_data !== 8'hFA) begin bad++; $display("FAIL mid_reset_scan got=%b/%02h want=0/FA", scan_valid, scan_data); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_byte = 8'h00; cmd_has_arg = 1'b0; cmd_arg = 8'h00;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_cmd_with_arg();
        test_resend_ok();
        test_retry_exhausted();
        test_bat_timeout();
        test_bat_results();
        test_cmd_timeout();
        test_ack_beats_timeout();
        test_nak();
        test_scan_forward();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
